freq_meter: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/freq_meter_sync_edge_detect.sv | 28 ++
 rtl/freq_meter.sv | 91 +++++++++
 tb/tb_freq_meter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter.
`timescale 1ns/1ps
package freq_meter_pkg;

  typedef enum logic {
    IDLE,
    GATE
  } state_t;

  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_CNT_W       = 27;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Two-flop synchronizer plus edge flop for one async input.
`timescale 1ns/1ps
module sync_edge_detect (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter; back-to-back windows, one result per window.
`timescale 1ns/1ps
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int GATE_CYCLES = CLK_FREQ_HZ,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq_hz,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (GATE_CYCLES < 4) begin : g_gate_chk
    $error("freq_meter: GATE_CYCLES must be >= 4");
  end

  state_t           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_acc;
  logic             rise;
  logic             sat_hit;
  logic [CNT_W-1:0] edge_nxt;

  sync_edge_detect u_sync (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .async_in   (sig_in),
    .rise       (rise)
  );

  // Saturating add of this cycle's edge
  assign sat_hit  = rise & (edge_cnt == CNT_MAX);
  assign edge_nxt = sat_hit ? CNT_MAX : edge_cnt + CNT_W'(rise);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_acc    <= 1'b0;
      freq_hz    <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf_acc  <= 1'b0;
          if (enable) state <= GATE;
        end
        GATE: begin
          if (!enable) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            freq_hz    <= edge_nxt;
            overflow   <= ovf_acc | sat_hit;
            freq_valid <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_acc    <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= edge_nxt;
            ovf_acc  <= ovf_acc | sat_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == GATE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: GATE_CYCLES=100, CNT_W=8 and CNT_W=4.
`timescale 1ns/1ps
module tb_freq_meter;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic       sig_in;
  logic       enable;
  logic [7:0] freq_hz;
  logic       freq_valid;
  logic       overflow;
  logic       busy;
  logic [3:0] freq_hz4;
  logic       freq_valid4;
  logic       overflow4;
  logic       busy4;

  int total = 0;
  int bad   = 0;

  int   sq_period = 0;
  int   sq_ph     = 0;
  int   sq_last   = 0;
  logic sq_val    = 1'b0;
  logic sig_man   = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) u_dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .freq_hz    (freq_hz),
    .freq_valid (freq_valid),
    .overflow   (overflow),
    .busy       (busy)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_dut4 (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .freq_hz    (freq_hz4),
    .freq_valid (freq_valid4),
    .overflow   (overflow4),
    .busy       (busy4)
  );

  // Square wave: high for the first half of each period
  always @(posedge clk_100MHz) begin
    #1;
    if (sq_period != sq_last) begin
      sq_ph   = 0;
      sq_last = sq_period;
    end
    if (sq_period != 0) begin
      sq_val = (sq_ph < sq_period / 2);
      sq_ph  = (sq_ph + 1) % sq_period;
    end
  end

  assign sig_in = (sq_period != 0) ? sq_val : sig_man;

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!freq_valid && n < 400);
    if (!freq_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: no freq_valid within %0d clks", n);
    end
  endtask

  task automatic wait_neg(input int k);
    for (int i = 0; i < k; i++) @(negedge clk_100MHz);
  endtask

  task automatic start_enable();
    @(posedge clk_100MHz);
    #1 enable = 1'b1;
    @(posedge clk_100MHz);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    total++;
    if (freq_hz !== 8'd0) begin
      bad++;
      $display("FAIL reset_freq: got %0d want 0", freq_hz);
    end
    total++;
    if (freq_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got v=%b o=%b b=%b want 0 0 0",
               freq_valid, overflow, busy);
    end
    wait_neg(3);
    reset_n = 1'b1;
    wait_neg(5);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_square();
    int n;
    sq_period = 10;
    wait_neg(20);
    start_enable();
    wait_valid(n);
    total++;
    if (n !== 101) begin
      bad++;
      $display("FAIL first_latency: got %0d want 101", n);
    end
    for (int w = 0; w < 2; w++) begin
      wait_valid(n);
      total++;
      if (n !== 100) begin
        bad++;
        $display("FAIL window_period: got %0d want 100", n);
      end
      total++;
      if (freq_hz !== 8'd10 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL square10: got f=%0d o=%b want 10 0", freq_hz, overflow);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    int seen;
    wait_neg(50);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_pre: got %b want 1", busy);
    end
    enable = 1'b0;
    @(negedge clk_100MHz);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy: got %b want 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_100MHz);
      if (freq_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_valid: got %0d strobes want 0", seen);
    end
    total++;
    if (freq_hz !== 8'd10) begin
      bad++;
      $display("FAIL abort_hold: got %0d want 10", freq_hz);
    end
    start_enable();
    wait_valid(n);
    total++;
    if (n !== 101 || freq_hz !== 8'd10) begin
      bad++;
      $display("FAIL reenable: got n=%0d f=%0d want 101 10", n, freq_hz);
    end
  endtask

  task automatic test_single_edge();
    int n;
    sig_man   = 1'b0;
    sq_period = 0;
    wait_valid(n);
    wait_neg(50);
    sig_man = 1'b1;
    wait_valid(n);
    total++;
    if (freq_hz !== 8'd1) begin
      bad++;
      $display("FAIL single_edge: got %0d want 1", freq_hz);
    end
    wait_valid(n);
    total++;
    if (freq_hz !== 8'd0) begin
      bad++;
      $display("FAIL single_after: got %0d want 0", freq_hz);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    sq_period = 10;
    wait_valid(n);
    wait_neg(70);
    reset_n = 1'b0;
    #1;
    total++;
    if (freq_hz !== 8'd0 || freq_valid !== 1'b0 ||
        overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got f=%0d v=%b o=%b b=%b want 0",
               freq_hz, freq_valid, overflow, busy);
    end
    wait_neg(2);
    reset_n = 1'b1;
    wait_valid(n);
    total++;
    if (n !== 101) begin
      bad++;
      $display("FAIL reset_latency: got %0d want 101", n);
    end
  endtask

  task automatic test_overflow();
    int n;
    sq_period = 4;
    wait_valid(n);
    wait_valid(n);
    total++;
    if (freq_hz4 !== 4'd15 || overflow4 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sat: got f=%0d o=%b want 15 1", freq_hz4, overflow4);
    end
    total++;
    if (freq_hz !== 8'd25 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_wide: got f=%0d o=%b want 25 0", freq_hz, overflow);
    end
    sq_period = 20;
    wait_valid(n);
    wait_valid(n);
    total++;
    if (freq_hz4 !== 4'd5 || overflow4 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got f=%0d o=%b want 5 0", freq_hz4, overflow4);
    end
  endtask

  task automatic test_boundary();
    int n;
    sig_man   = 1'b0;
    sq_period = 0;
    wait_valid(n);
    wait_valid(n);
    // sig_in set at gate cycle k yields rise in gate cycle k+2
    wait_neg(97);
    sig_man = 1'b1;
    wait_valid(n);
    total++;
    if (freq_hz !== 8'd1) begin
      bad++;
      $display("FAIL edge_cycle99: got %0d want 1", freq_hz);
    end
    @(negedge clk_100MHz);
    total++;
    if (freq_valid !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width99: got %b want 0", freq_valid);
    end
    sig_man = 1'b0;
    wait_neg(97);
    sig_man = 1'b1;
    wait_valid(n);
    total++;
    if (freq_hz !== 8'd0) begin
      bad++;
      $display("FAIL edge_not_early: got %0d want 0", freq_hz);
    end
    @(negedge clk_100MHz);
    total++;
    if (freq_valid !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width0: got %b want 0", freq_valid);
    end
    wait_valid(n);
    total++;
    if (freq_hz !== 8'd1) begin
      bad++;
      $display("FAIL edge_cycle0: got %0d want 1", freq_hz);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_abort();
    test_single_edge();
    test_reset_mid();
    test_overflow();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
